dc_mem_ctrl: RTL and testbench
==============================

# dc_mem_ctrl

Memory-side controller for the direct-mapped data cache and the instruction cache. It services dcache line misses (with optional dirty eviction), uncached IO accesses and icache line fills over one shared 32-bit memory/IO bus. It round-robin arbitrates between the data and instruction sides, sequences the 4-beat line transfers and returns a one-cycle acknowledge to the requester. It sits between the cache pipeline stages and the system bus model, in the MMU.

## Interface
- No parameters; line = 128 bits = 4 beats of 32 bits (fixed).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- dc_miss  in  1  dcache line miss pending; held until dc_miss_ack
- dc_miss_addr  in  32  line-aligned fill address ([3:0]=0)
- dc_evict  in  1  victim dirty; qualifies dc_miss, write-back required first
- dc_evict_addr  in  32  line-aligned victim address
- dc_evict_data  in  128  victim line, stable while dc_miss high
- dc_data_fill  out  128  registered fill line
- dc_miss_ack  out  1  one-cycle pulse, fill complete, dc_data_fill valid
- io_access  in  1  uncached access pending; held until io_ack
- io_rw  in  1  1=write, 0=read
- io_addr  in  32  word-aligned IO address
- io_wr_data  in  32  IO write data
- io_rd_data  out  32  registered IO read data
- io_ack  out  1  one-cycle pulse, IO access complete
- ic_miss  in  1  icache line miss pending; held until ic_miss_ack
- ic_miss_addr  in  32  line-aligned fill address
- ic_data_fill  out  128  registered icache fill line
- ic_miss_ack  out  1  one-cycle pulse
- mem_req  out  1  bus beat request
- mem_we  out  1  1=write beat
- mem_io  out  1  1=IO space, 0=memory space
- mem_addr  out  32  beat address
- mem_wdata  out  32  write beat data
- mem_rdata  in  32  read beat data, valid with mem_ack
- mem_ack  in  1  beat complete; may assert in the same cycle mem_req rises

## Operation
- States: IDLE, EVICT, DFILL, DACK, IO, IOACK, IFILL, IACK; 2-bit beat counter; last_grant flag (0=data side, 1=inst side).
- IDLE: data-side request = io_access | dc_miss; inst-side = ic_miss. Only one pending: grant it. Both pending: grant side opposite last_grant. Update last_grant on grant.
- Data grant: io_access -> IO; dc_miss & dc_evict -> EVICT; dc_miss & !dc_evict -> DFILL. io_access and dc_miss are never both high; if they are, io_access wins.
- EVICT: mem_req=1, mem_we=1, mem_io=0, mem_addr=dc_evict_addr+4*cnt, mem_wdata=dc_evict_data[32*cnt+31:32*cnt]. On mem_ack, cnt++. On ack of beat 3, cnt=0 and go to DFILL.
- DFILL: mem_we=0, mem_addr=dc_miss_addr+4*cnt. On mem_ack, capture mem_rdata into dc_data_fill[32*cnt+31:32*cnt] and cnt++. Beat 3 ack -> DACK.
- DACK: dc_miss_ack=1 for one cycle -> IDLE. IACK and IOACK behave the same with their own ack.
- IFILL: same as DFILL using ic_miss_addr and ic_data_fill -> IACK.
- IO: single beat, mem_io=1, mem_we=io_rw, mem_addr=io_addr, mem_wdata=io_wr_data. On mem_ack, capture mem_rdata into io_rd_data, but only on a read; writes leave it unchanged. Then -> IOACK.
- Fill and IO data registers hold until overwritten by the next transaction of the same type.
- mem_req=0 in IDLE and all ACK states. Requests are not re-sampled outside IDLE, and a granted transaction is never preempted.
- Requesters drop their request in the cycle after the ack. IDLE is the only sampling point, so a request is never double-served.

## Timing
- Reset values: state=IDLE, cnt=0, last_grant=1 (data side wins the first tie). All outputs are 0, including dc_data_fill, ic_data_fill and io_rd_data.
- Reset mid-transaction: abandon at the next edge; mem_req low the cycle after rst is sampled; no ack issued.
- Bus outputs are decoded from registered state and cnt only; no combinational path from mem_ack.
- A beat completes in any cycle with mem_req & mem_ack. mem_req stays high across consecutive beats; addr and data advance the cycle after each ack.
- Latency with zero-wait memory (mem_ack tied high), request seen in IDLE at cycle 0:
  - clean dcache miss: fill beats in cycles 1-4, dc_miss_ack in cycle 5
  - dirty miss: evict beats 1-4, fill beats 5-8, ack in cycle 9
  - IO: beat in cycle 1, io_ack in cycle 2
  - icache fill: ack in cycle 5
- Each wait cycle (mem_req & !mem_ack) adds exactly one cycle.
- Address arithmetic: beat address = base + {cnt,2'b00}, 32-bit add with no carry out; base[3:0]=0, so no wrap within a line.

## Test plan
- Clean miss: dc_miss, addr 0x0000_0120, mem returns 0x11111111..0x44444444, zero wait -> reads at 0x120/124/128/12C; dc_data_fill=0x44444444_33333333_22222222_11111111; dc_miss_ack in cycle 5.
- Dirty miss: dc_evict_addr 0x0000_0A40, data 0xDDDD..AAAA -> 4 write beats at 0xA40-0xA4C, low word first, then fill; ack in cycle 9. Repeat with 2 wait cycles per beat -> ack in cycle 25.
- IO: read at 0x0000_F004 with mem_rdata 0xCAFEBABE -> mem_io=1, io_rd_data=0xCAFEBABE, io_ack in cycle 2. Then an IO write -> mem_we=1, io_rd_data unchanged.
- Arbitration: dc_miss and ic_miss raised together from reset -> dcache served first, icache next. Both raised again -> dcache served first again, because last_grant now points at the icache.
- Reset during DFILL beat 2 -> mem_req=0 next cycle, no dc_miss_ack, state IDLE. A re-issued miss completes normally.

Source files
------------

// File: rtl/dc_mem_ctrl_if.sv
// Cache-side request/acknowledge signals and the shared memory/IO bus of dc_mem_ctrl.
// The master modport is the controller; the slave modport is the caches plus the bus model.
interface dc_mem_ctrl_if;
    logic         dc_miss;
    logic [31:0]  dc_miss_addr;
    logic         dc_evict;
    logic [31:0]  dc_evict_addr;
    logic [127:0] dc_evict_data;
    logic [127:0] dc_data_fill;
    logic         dc_miss_ack;

    logic         io_access;
    logic         io_rw;
    logic [31:0]  io_addr;
    logic [31:0]  io_wr_data;
    logic [31:0]  io_rd_data;
    logic         io_ack;

    logic         ic_miss;
    logic [31:0]  ic_miss_addr;
    logic [127:0] ic_data_fill;
    logic         ic_miss_ack;

    logic         mem_req;
    logic         mem_we;
    logic         mem_io;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;

    modport master (
        input  dc_miss, dc_miss_addr, dc_evict, dc_evict_addr, dc_evict_data,
        output dc_data_fill, dc_miss_ack,
        input  io_access, io_rw, io_addr, io_wr_data,
        output io_rd_data, io_ack,
        input  ic_miss, ic_miss_addr,
        output ic_data_fill, ic_miss_ack,
        output mem_req, mem_we, mem_io, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output dc_miss, dc_miss_addr, dc_evict, dc_evict_addr, dc_evict_data,
        input  dc_data_fill, dc_miss_ack,
        output io_access, io_rw, io_addr, io_wr_data,
        input  io_rd_data, io_ack,
        output ic_miss, ic_miss_addr,
        input  ic_data_fill, ic_miss_ack,
        input  mem_req, mem_we, mem_io, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dc_mem_ctrl.sv
// Memory-side controller: round-robin arbitration between dcache (miss/evict/IO) and icache
// fills, sequencing 4-beat line transfers and single IO beats over one shared 32-bit bus.
module dc_mem_ctrl (
    input  logic          clk,
    input  logic          rst,
    dc_mem_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        EVICT,
        DFILL,
        DACK,
        IO,
        IOACK,
        IFILL,
        IACK
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        last_grant;

    logic        data_req;
    logic        inst_req;
    logic        grant_data;
    logic        grant_inst;
    logic        beat_done;
    logic [31:0] beat_off;
    logic [6:0]  lane;

    assign data_req   = bus.io_access | bus.dc_miss;
    assign inst_req   = bus.ic_miss;
    // On a tie the side not served last time wins; last_grant=1 means inst was last.
    assign grant_inst = inst_req & (~data_req | ~last_grant);
    assign grant_data = data_req & ~grant_inst;

    assign beat_off   = {28'd0, cnt, 2'b00};
    assign lane       = {cnt, 5'b00000};
    assign beat_done  = bus.mem_req & bus.mem_ack;

    // Bus outputs depend only on registered state/cnt and the stable request fields.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_io    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            EVICT: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.dc_evict_addr + beat_off;
                bus.mem_wdata = bus.dc_evict_data[lane +: 32];
            end
            DFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.dc_miss_addr + beat_off;
            end
            IFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.ic_miss_addr + beat_off;
            end
            IO: begin
                bus.mem_req   = 1'b1;
                bus.mem_io    = 1'b1;
                bus.mem_we    = bus.io_rw;
                bus.mem_addr  = bus.io_addr;
                bus.mem_wdata = bus.io_wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            last_grant       <= 1'b1;
            bus.dc_data_fill <= '0;
            bus.ic_data_fill <= '0;
            bus.io_rd_data   <= '0;
            bus.dc_miss_ack  <= 1'b0;
            bus.ic_miss_ack  <= 1'b0;
            bus.io_ack       <= 1'b0;
        end else begin
            bus.dc_miss_ack <= 1'b0;
            bus.ic_miss_ack <= 1'b0;
            bus.io_ack      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_data) begin
                        last_grant <= 1'b0;
                        if (bus.io_access)
                            state <= IO;
                        else if (bus.dc_evict)
                            state <= EVICT;
                        else
                            state <= DFILL;
                    end else if (grant_inst) begin
                        last_grant <= 1'b1;
                        state      <= IFILL;
                    end
                end
                EVICT: begin
                    if (beat_done) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= DFILL;
                    end
                end
                DFILL: begin
                    if (beat_done) begin
                        bus.dc_data_fill[lane +: 32] <= bus.mem_rdata;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state           <= DACK;
                            bus.dc_miss_ack <= 1'b1;
                        end
                    end
                end
                IFILL: begin
                    if (beat_done) begin
                        bus.ic_data_fill[lane +: 32] <= bus.mem_rdata;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state           <= IACK;
                            bus.ic_miss_ack <= 1'b1;
                        end
                    end
                end
                IO: begin
                    if (beat_done) begin
                        if (!bus.io_rw)
                            bus.io_rd_data <= bus.mem_rdata;
                        state      <= IOACK;
                        bus.io_ack <= 1'b1;
                    end
                end
                DACK, IACK, IOACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_mem_ctrl.sv
// Bench for dc_mem_ctrl: a bus responder checks every beat against queued expectations and
// an ack monitor checks kind, cycle and returned data against a queue of expected completions.
module tb_dc_mem_ctrl;

    localparam int K_DC = 0;
    localparam int K_IC = 1;
    localparam int K_IO = 2;

    typedef struct {
        logic        we;
        logic        io;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        int           kind;
        int           cyc;
        logic [127:0] data;
    } ack_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   wait_cycles = 0;
    int   wait_cnt = 0;

    beat_t beat_q[$];
    ack_t  ack_q[$];

    dc_mem_ctrl_if bus();

    dc_mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bus model: answers each requested beat after wait_cycles stall cycles.
    initial begin
        beat_t b;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!bus.mem_req) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (wait_cnt < wait_cycles) begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end else begin
                bus.mem_ack = 1'b1;
                wait_cnt    = 0;
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", {96'd0, bus.mem_addr}, 128'hFFFF_FFFF);
                    bus.mem_rdata = '0;
                end else begin
                    b = beat_q.pop_front();
                    check("beat_we", bus.mem_we, b.we);
                    check("beat_io", bus.mem_io, b.io);
                    check("beat_addr", bus.mem_addr, b.addr);
                    if (b.we)
                        check("beat_wdata", bus.mem_wdata, b.wdata);
                    bus.mem_rdata = b.rdata;
                end
            end
        end
    end

    task automatic check_ack(input int kind, input logic [127:0] data);
        ack_t e;
        if (ack_q.size() == 0) begin
            check("ack_unexpected", kind, 99);
        end else begin
            e = ack_q.pop_front();
            check("ack_kind", kind, e.kind);
            check("ack_cycle", cyc, e.cyc);
            check("ack_data", data, e.data);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.dc_miss_ack) check_ack(K_DC, bus.dc_data_fill);
            if (bus.ic_miss_ack) check_ack(K_IC, bus.ic_data_fill);
            if (bus.io_ack)      check_ack(K_IO, {96'd0, bus.io_rd_data});
        end
    end

    task automatic issue_dc(input logic [31:0] addr, input logic evict, input logic [31:0] eaddr,
                            input logic [127:0] edata, input logic [127:0] fill, input int lat);
        if (evict)
            for (int i = 0; i < 4; i++)
                beat_q.push_back('{1'b1, 1'b0, eaddr + 32'(4 * i), edata[32 * i +: 32], 32'd0});
        for (int i = 0; i < 4; i++)
            beat_q.push_back('{1'b0, 1'b0, addr + 32'(4 * i), 32'd0, fill[32 * i +: 32]});
        ack_q.push_back('{K_DC, cyc + lat, fill});
        bus.dc_miss_addr  = addr;
        bus.dc_evict      = evict;
        bus.dc_evict_addr = eaddr;
        bus.dc_evict_data = edata;
        bus.dc_miss       = 1'b1;
    endtask

    task automatic issue_ic(input logic [31:0] addr, input logic [127:0] fill, input int lat);
        for (int i = 0; i < 4; i++)
            beat_q.push_back('{1'b0, 1'b0, addr + 32'(4 * i), 32'd0, fill[32 * i +: 32]});
        ack_q.push_back('{K_IC, cyc + lat, fill});
        bus.ic_miss_addr = addr;
        bus.ic_miss      = 1'b1;
    endtask

    task automatic issue_io(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] mem_data, input logic [31:0] exp_rd, input int lat);
        beat_q.push_back('{rw, 1'b1, addr, wdata, mem_data});
        ack_q.push_back('{K_IO, cyc + lat, {96'd0, exp_rd}});
        bus.io_rw      = rw;
        bus.io_addr    = addr;
        bus.io_wr_data = wdata;
        bus.io_access  = 1'b1;
    endtask

    // Requester side: waits (bounded) for its ack, drops the request the cycle after.
    task automatic wait_ack(input int kind);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            case (kind)
                K_DC:    seen = bus.dc_miss_ack;
                K_IC:    seen = bus.ic_miss_ack;
                default: seen = bus.io_ack;
            endcase
        end
        check("ack_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        case (kind)
            K_DC:    bus.dc_miss = 1'b0;
            K_IC:    bus.ic_miss = 1'b0;
            default: bus.io_access = 1'b0;
        endcase
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fill_a, fill_b, last_dc_fill;
        int start;

        bus.dc_miss = 1'b0; bus.dc_miss_addr = '0; bus.dc_evict = 1'b0;
        bus.dc_evict_addr = '0; bus.dc_evict_data = '0;
        bus.io_access = 1'b0; bus.io_rw = 1'b0; bus.io_addr = '0; bus.io_wr_data = '0;
        bus.ic_miss = 1'b0; bus.ic_miss_addr = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we_io", {bus.mem_we, bus.mem_io}, 2'b00);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_dc_fill", bus.dc_data_fill, 128'd0);
        check("rst_ic_fill", bus.ic_data_fill, 128'd0);
        check("rst_io_rd", bus.io_rd_data, 32'd0);
        check("rst_acks", {bus.dc_miss_ack, bus.ic_miss_ack, bus.io_ack}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Tie from reset: data side first, then icache right after DACK.
        @(posedge clk); #1;
        fill_a = 128'h0A0A0A03_0A0A0A02_0A0A0A01_0A0A0A00;
        fill_b = 128'h1B1B1B03_1B1B1B02_1B1B1B01_1B1B1B00;
        issue_dc(32'h0000_0300, 1'b0, '0, '0, fill_a, 5);
        issue_ic(32'h0000_1000, fill_b, 11);
        fork
            wait_ack(K_DC);
            wait_ack(K_IC);
        join
        @(posedge clk); #1;
        fill_a = 128'h2C2C2C03_2C2C2C02_2C2C2C01_2C2C2C00;
        fill_b = 128'h3D3D3D03_3D3D3D02_3D3D3D01_3D3D3D00;
        issue_dc(32'h0000_0340, 1'b0, '0, '0, fill_a, 5);
        issue_ic(32'h0000_1040, fill_b, 11);
        fork
            wait_ack(K_DC);
            wait_ack(K_IC);
        join
        check("dc_fill_hold", bus.dc_data_fill, fill_a);

        // Clean miss, zero wait.
        @(posedge clk); #1;
        issue_dc(32'h0000_0120, 1'b0, '0, '0,
                 128'h44444444_33333333_22222222_11111111, 5);
        wait_ack(K_DC);

        // Dirty miss, zero wait then two wait cycles per beat.
        @(posedge clk); #1;
        issue_dc(32'h0000_0200, 1'b1, 32'h0000_0A40,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                 128'h88888888_77777777_66666666_55555555, 9);
        wait_ack(K_DC);
        wait_cycles = 2;
        @(posedge clk); #1;
        issue_dc(32'h0000_0280, 1'b1, 32'h0000_0A40,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                 128'hF0F0F0F3_F0F0F0F2_F0F0F0F1_F0F0F0F0, 25);
        wait_ack(K_DC);
        wait_cycles = 0;

        // IO read then write; a write must not disturb io_rd_data.
        @(posedge clk); #1;
        issue_io(1'b0, 32'h0000_F004, 32'h0, 32'hCAFE_BABE, 32'hCAFE_BABE, 2);
        wait_ack(K_IO);
        @(posedge clk); #1;
        issue_io(1'b1, 32'h0000_F008, 32'h1234_5678, 32'hDEAD_0000, 32'hCAFE_BABE, 2);
        wait_ack(K_IO);

        // Lone icache fill with one wait cycle per beat: 1 + 4*2.
        wait_cycles = 1;
        @(posedge clk); #1;
        issue_ic(32'h0000_2000, 128'h99999999_12121212_34343434_56565656, 9);
        wait_ack(K_IC);
        wait_cycles = 0;

        // Reset in DFILL beat 2: bus idles next cycle, no ack, then a fresh miss completes.
        @(posedge clk); #1;
        start = cyc;
        for (int i = 0; i < 3; i++)
            beat_q.push_back('{1'b0, 1'b0, 32'h0000_0400 + 32'(4 * i), 32'd0, 32'h7700_0000 + 32'(i)});
        bus.dc_miss_addr = 32'h0000_0400;
        bus.dc_evict     = 1'b0;
        bus.dc_miss      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_cycle", cyc - start, 3);
        rst         = 1'b1;
        bus.dc_miss = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_mem_req", bus.mem_req, 1'b0);
        check("rst_mid_ack", bus.dc_miss_ack, 1'b0);
        check("rst_mid_fill", bus.dc_data_fill, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue_dc(32'h0000_0400, 1'b0, '0, '0,
                 128'h7700_0003_7700_0002_7700_0001_7700_0000, 5);
        wait_ack(K_DC);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("beat_q_empty", beat_q.size(), 0);
        check("ack_q_empty", ack_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
